// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with keypad loading, pause/resume and a prescaled 1 s tick.
// Build option: define COUNTDOWN_TIMER_ADD30_EN to include the "+30 s" button logic.
module countdown_timer #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 1
) (
    input  logic                    CLK,
    input  logic                    clear,
    input  logic [3:0]              digit,
    input  logic                    digit_valid,
    input  logic                    loadn,
    input  logic                    enable,
    input  logic                    add30,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic [3:0]              tens_secs,
    output logic [3:0]              secs,
    output logic                    timer_done,
    output logic                    done_pulse
);

    // Time is one packed BCD word: nibble 0 = secs, nibble 1 = tens_secs, nibbles 2.. = minutes.
    localparam int ND = MIN_DIGITS + 2;
    localparam int TW = 4 * ND;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [TW-1:0] time_q;
    logic [TW-1:0] time_d;
    logic [TW-1:0] dec_t;
    logic [PW-1:0] prescaler;
    logic          running;
    logic          tick;
    logic          load_stb;
    logic          borrow;

    assign minutes    = time_q[TW-1:8];
    assign tens_secs  = time_q[7:4];
    assign secs       = time_q[3:0];
    assign timer_done = (time_q == '0);

    // digit_valid is a one-cycle strobe without back-pressure: every strobe seen in
    // load mode is consumed on that same edge (stored if digit <= 9, dropped otherwise).
    assign load_stb = !loadn && digit_valid;
    assign running  = loadn && enable && !timer_done;
    assign tick     = running && (prescaler == PS_LAST);

    // One-second decrement; never evaluated at zero, so the borrow never leaves the top digit.
    always_comb begin
        dec_t  = time_q;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (time_q[4*i +: 4] == 4'd0) begin
                    dec_t[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    dec_t[4*i +: 4] = time_q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

`ifdef COUNTDOWN_TIMER_ADD30_EN
    logic [TW-1:0] add_base;
    logic [TW-1:0] add_t;
    logic [4:0]    tens_sum;
    logic          carry;

    // +30 s is applied on top of a coincident tick, so both take effect together.
    always_comb begin
        add_base = tick ? dec_t : time_q;
        add_t    = add_base;
        tens_sum = {1'b0, add_base[7:4]} + 5'd3;
        carry    = (tens_sum >= 5'd6);
        if (carry) begin
            tens_sum = tens_sum - 5'd6;
        end
        add_t[7:4] = tens_sum[3:0];
        for (int i = 2; i < ND; i++) begin
            if (carry) begin
                if (add_base[4*i +: 4] >= 4'd9) begin
                    add_t[4*i +: 4] = 4'd0;
                end else begin
                    add_t[4*i +: 4] = add_base[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        if (carry) begin
            for (int i = 2; i < ND; i++) begin
                add_t[4*i +: 4] = 4'd9;
            end
            add_t[7:4] = 4'd5;
            add_t[3:0] = 4'd9;
        end
    end
`else
    logic unused_add30;
    assign unused_add30 = add30;
`endif

    always_comb begin
        time_d = time_q;
        if (load_stb) begin
            if (digit <= 4'd9) begin
                time_d = {time_q[TW-5:0], digit};
            end
        end
`ifdef COUNTDOWN_TIMER_ADD30_EN
        else if (add30) begin
            time_d = add_t;
        end
`endif
        else if (tick) begin
            time_d = dec_t;
        end
    end

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            time_q     <= '0;
            prescaler  <= '0;
            done_pulse <= 1'b0;
        end else begin
            time_q     <= time_d;
            done_pulse <= tick && (time_d == '0);
            if (!loadn) begin
                prescaler <= '0;
            end else if (running) begin
                prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PW'(1);
            end
        end
    end

endmodule
